fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the multicycle RISC-V core: owns the PC and instruction register, fetches from instruction memory over a variable-latency request/response handshake, and buffers fetched words in a small prefetch queue. It is the successor to the fixed-latency PC/IR path. It decouples fetch from the control unit and adds redirect/flush and configurable width, step and depth.

---
 rtl/fetch_queue_unit.sv | 207 ++++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// ============================================================================
//  Module      : fetch_queue_unit
//  Description : Instruction-fetch front end. Owns the fetch PC, issues
//                single-outstanding requests to instruction memory over a
//                variable-latency strobe handshake, and buffers returned
//                words with their PCs in a circular prefetch queue.
//                Supports redirect/flush with discard of in-flight responses.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                fetch_en                 - permits new memory requests
//                imem_req / imem_addr     - request strobe and address
//                imem_valid / imem_rdata  - response strobe and data
//                instr_valid/instr/instr_pc/instr_ready - queue head and pop
//                redirect / redirect_pc   - flush and restart fetch
//                fetch_pc                 - address of the next request
//                fetch_fault              - sticky misaligned-redirect flag
//  Options     : FETCH_ALIGN_CHECK_EN - when defined, a misaligned redirect
//                sets fetch_fault and halts fetch until reset; when not
//                defined, redirect_pc[1:0] is cleared on load and
//                fetch_fault is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_queue_unit #(
    parameter int unsigned     XLEN      = 64,
    parameter int unsigned     ILEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     PC_STEP   = 4,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_fault
);

    localparam int unsigned     c_AW    = $clog2(BUF_DEPTH);
    localparam logic [c_AW+1:0] c_DEPTH = (c_AW+2)'(BUF_DEPTH);
    localparam logic [XLEN-1:0] c_STEP  = XLEN'(PC_STEP);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_DROP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [c_AW:0]   r_count;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [ILEN-1:0] r_ins_mem [BUF_DEPTH];
    logic [XLEN-1:0] r_pc_mem  [BUF_DEPTH];

    logic            w_fault;
    logic            w_push;
    logic            w_pop;
    logic [c_AW+1:0] w_occ_sum;
    logic            w_issue;
    logic [XLEN-1:0] w_fetch_pc_inc;
    logic [XLEN-1:0] w_redirect_pc;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign w_fetch_pc_inc = r_fetch_pc + c_STEP;

    // A response is kept only in WAIT and only if no redirect flushes it.
    assign w_push = (r_state == c_S_WAIT) & imem_valid & ~redirect;
    assign instr_valid = (r_count != '0);
    assign w_pop  = instr_valid & instr_ready;

    // Room check counts this cycle's push but deliberately ignores this
    // cycle's pop, keeping instr_ready off the request path.
    assign w_occ_sum = {1'b0, r_count} + (c_AW+2)'(w_push);
    assign w_issue   = fetch_en & ~redirect & ~w_fault & ~rst
                     & (w_occ_sum < c_DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    assign w_redirect_pc = redirect_pc;
    assign w_fault       = r_fault;
    assign fetch_fault   = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end
`else
    assign w_redirect_pc = redirect_pc & ~(XLEN'(3));
    assign w_fault       = 1'b0;
    assign fetch_fault   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. w_issue is already false under redirect, so a
    // response arriving with redirect always lands in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_issue) w_state_next = c_S_WAIT;
            end
            c_S_WAIT: begin
                if (imem_valid)    w_state_next = w_issue ? c_S_WAIT : c_S_IDLE;
                else if (redirect) w_state_next = c_S_DROP;
            end
            c_S_DROP: begin
                if (imem_valid) w_state_next = w_issue ? c_S_WAIT : c_S_IDLE;
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. A back-to-back request from WAIT targets the PC that
    // follows the word being accepted this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_fetch_pc;
        case (r_state)
            c_S_IDLE: imem_req = w_issue;
            c_S_WAIT: begin
                imem_req = imem_valid & w_issue;
                if (imem_valid) imem_addr = w_fetch_pc_inc;
            end
            c_S_DROP: imem_req = imem_valid & w_issue;
            default:  imem_req = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= w_fetch_pc_inc;
        end
    end

    assign fetch_pc = r_fetch_pc;

    // ------------------------------------------------------------------
    // Prefetch queue: pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ins_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
        end
    end

    assign instr    = instr_valid ? r_ins_mem[r_rd_ptr] : '0;
    assign instr_pc = instr_valid ? r_pc_mem[r_rd_ptr]  : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// ============================================================================
//  Module      : tb_fetch_queue_unit
//  Description : Self-checking bench for fetch_queue_unit. A driver applies
//                randomized fetch/consume/redirect traffic and a variable
//                latency memory, keeps a reference model of the fetch
//                stream, and pushes expected queue entries to a scoreboard;
//                a monitor pops and compares on every consumer handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_queue_unit;

    localparam int          XLEN  = 64;
    localparam int          ILEN  = 32;
    localparam int          DEPTH = 2;
    localparam int          STEP  = 4;
    localparam logic [63:0] RPC   = 64'hFFFF_FFFF_FFFF_FFFC;

    logic            clk;
    logic            rst;
    logic            fetch_en;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [ILEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_fault;

    fetch_queue_unit #(
        .XLEN      (XLEN),
        .ILEN      (ILEN),
        .RESET_PC  (RPC),
        .PC_STEP   (STEP),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     model_on = 0;
    int     req_count = 0;

    // Reference model of the fetch stream
    logic [63:0] m_pc;
    logic [63:0] m_addr;
    bit          m_out;
    bit          m_stale;
    bit          m_fault;
    int          m_lat;
    bit          p_clear;
    bit          p_push;
    entry_t      p_entry;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] | 32'h13;
    endfunction

    // Monitor: queue head visibility and in-order delivery
    always @(negedge clk) begin
        if (model_on) begin
            chk("instr_valid", {63'd0, instr_valid}, {63'd0, (sb.size() != 0)});
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_empty: got pc %h, expected no entry", instr_pc);
                end else begin
                    entry_t e;
                    e = sb.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr", {32'd0, instr}, {32'd0, e.ins});
                end
            end
        end
    end

    task automatic model_init();
        m_pc    = RPC;
        m_addr  = '0;
        m_out   = 0;
        m_stale = 0;
        m_fault = 0;
        m_lat   = 0;
        p_clear = 0;
        p_push  = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        bit ghost;
        ghost       = m_out;
        model_on    = 0;
        rst         = 1'b1;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_valid  = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_imem_addr", imem_addr, RPC);
        chk("rst_fetch_pc", fetch_pc, RPC);
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);
        chk("rst_fetch_fault", {63'd0, fetch_fault}, 64'd0);
        rst = 1'b0;
        model_init();
        // A response to a request cut off by reset must be ignored.
        imem_valid = ghost;
        imem_rdata = $urandom;
        model_on   = 1;
        #1;
        chk("post_rst_req", {63'd0, imem_req}, 64'd0);
    endtask

    task automatic step(input int ready_pct, input int redir_pct,
                        input int lat_min, input int lat_max, input int en_pct);
        bit          resp;
        bit          accept;
        bit          exp_req;
        logic [63:0] exp_addr;
        logic [63:0] rp;
        @(posedge clk);
        #1;
        if (p_clear) sb.delete();
        if (p_push)  sb.push_back(p_entry);
        p_clear = 0;
        p_push  = 0;
        chk("fetch_pc", fetch_pc, m_pc);
        chk("fetch_fault", {63'd0, fetch_fault}, {63'd0, m_fault});

        fetch_en    = ($urandom_range(99) < en_pct);
        instr_ready = ($urandom_range(99) < ready_pct);
        redirect    = ($urandom_range(99) < redir_pct);
        rp = {$urandom, $urandom};
        if ($urandom_range(3) == 0) rp[63:12] = '1;
        if ($urandom_range(9) != 0) rp[1:0] = 2'b00;
        redirect_pc = rp;
        if (m_out && m_lat == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_data(m_addr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (m_out) m_lat--;
        end
        #1;
        resp     = imem_valid;
        accept   = resp && m_out && !m_stale && !redirect;
        exp_req  = fetch_en && !redirect && !m_fault && (!m_out || resp)
                   && ((sb.size() + int'(accept)) < DEPTH);
        exp_addr = accept ? m_pc + 64'(STEP) : m_pc;
        chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        if (imem_req === 1'b1) req_count++;

        if (resp) begin
            m_out   = 0;
            m_stale = 0;
        end
        if (redirect) begin
            p_clear = 1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) m_fault = 1;
            m_pc = redirect_pc;
`else
            m_pc = redirect_pc & ~64'd3;
`endif
            if (m_out) m_stale = 1;
        end else if (accept) begin
            p_push  = 1;
            p_entry = '{pc: m_pc, ins: mem_data(m_addr)};
            m_pc    = m_pc + 64'(STEP);
        end
        if (exp_req) begin
            m_out   = 1;
            m_stale = 0;
            m_addr  = exp_addr;
            m_lat   = $urandom_range(lat_max, lat_min);
        end
    endtask

    initial begin
        model_init();
        do_reset();

        // Streaming with 1-cycle memory; crosses the top of the address space.
        repeat (40) step(100, 0, 0, 0, 100);

        // Consumer stalled: exactly DEPTH requests, then fetch resumes.
        do_reset();
        req_count = 0;
        repeat (15) step(0, 0, 0, 0, 100);
        chk("stall_requests", 64'(req_count), 64'(DEPTH));
        repeat (20) step(100, 0, 0, 0, 100);

        // Slow memory with redirects.
        do_reset();
        repeat (300) step(100, 8, 2, 2, 100);

        // Fully randomized traffic, reset taken mid-flight between phases.
        for (int p = 0; p < 6; p++) begin
            do_reset();
            repeat (400) step(30 + p * 12, 5, 0, 2, 90);
        end

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
